i2c_reg_access: RTL and testbench
=================================

I2C_REG_ACCESS -- requirements
Module: i2c_reg_access

Interface
REQ-001 Parameter IDLE_GAP_CYCLES, default 0: idle clk cycles inserted between consecutive byte-engine operations.
REQ-002 clk  in  1  system clock; all logic rises on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request strobe; accepted only when req_ready=1.
REQ-005 req_ready  out  1  high only in IDLE.
REQ-006 req_rw  in  1  0=register write, 1=register read.
REQ-007 req_dev_addr  in  7  7-bit I2C device address.
REQ-008 req_reg_addr  in  8  device register index.
REQ-009 req_wdata  in  8  write data byte.
REQ-010 done  out  1  one-cycle pulse at transaction end.
REQ-011 rdata  out  8  read byte; valid from the done pulse, held until the next done.
REQ-012 nack  out  1  NACK seen during the transaction; valid with done, held until next accept.
REQ-013 i2c_command  out  2  to byte engine: 0=START, 1=STOP, 2=TX, 3=RX.
REQ-014 i2c_start  out  1  one-cycle engine launch strobe.
REQ-015 i2c_data_w  out  8  TX byte to engine.
REQ-016 i2c_r_ack  out  1  ACK bit driven by engine on RX; always 1 (NACK).
REQ-017 i2c_busy / i2c_w_ack / i2c_data_r  in  1/1/8  engine busy, received ACK bit (1=NACK), received byte.

Function
REQ-018 Write sequence: START, TX {dev,0}, TX reg, TX wdata, STOP (5 ops).
REQ-019 Read sequence: START, TX {dev,0}, TX reg, START (repeated), TX {dev,1}, RX, STOP (7 ops).
REQ-020 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP, FINISH; 3-bit op index selects command/data.
REQ-021 IDLE: on req_valid, latch all req_* fields, clear nack, op index=0, go ISSUE next cycle.
REQ-022 ISSUE: i2c_start=1 for exactly one cycle, i2c_command/i2c_data_w stable; next WAIT_ACK.
REQ-023 WAIT_ACK: one cycle unconditionally, because engine busy rises one cycle after start; next WAIT_DONE.
REQ-024 WAIT_DONE: hold until i2c_busy=0; then evaluate op result, go GAP (or ISSUE if IDLE_GAP_CYCLES=0).
REQ-025 After a TX op with i2c_w_ack=1, set nack.
REQ-026 After the RX op, capture i2c_data_r into rdata.
REQ-027 After STOP op, go FINISH: done=1 for one cycle, then IDLE.
REQ-028 i2c_command/i2c_data_w stay stable from ISSUE to WAIT_DONE exit.
REQ-029 req_valid outside IDLE is ignored; no queuing.
REQ-030 Back-to-back: a request presented in the cycle after done is accepted; min request-to-request spacing = 1 IDLE cycle.

Reset
REQ-031 Reset forces IDLE; req_ready=1, done=0, nack=0, rdata=0, i2c_start=0, i2c_command=0, i2c_data_w=0, i2c_r_ack=1.
REQ-032 Reset mid-transaction abandons it with no done pulse; the engine shares the same reset.

Configuration
REQ-033 Macro I2C_REG_ACCESS_NACK_ABORT_EN defined: a TX NACK skips the remaining ops and jumps straight to the STOP op, then FINISH.
REQ-034 Macro not defined: the sequence always runs to completion; nack is sticky OR of all TX ACK bits; read data is still captured.

Structure
REQ-035 Shared package i2c_pkg holds the command encodings (START/STOP/TX/RX) and the FSM state enum.
REQ-036 No sub-module: a flat FSM plus op-index decode; the byte engine is instantiated alongside by the integrator.

Verification
REQ-037 Write dev=0x3C reg=0x10 data=0xA5, all ACK -> engine sees START, TX 0x78, TX 0x10, TX 0xA5, STOP; done once; nack=0.
REQ-038 Read dev=0x50 reg=0x02, slave returns 0x5A -> START, TX 0xA0, TX 0x02, START, TX 0xA1, RX with r_ack=1, STOP; rdata=0x5A, nack=0.
REQ-039 Address NACK on write dev=0x22 -> with ABORT_EN: START, TX 0x44, STOP, nack=1; without it: all 5 ops, nack=1.
REQ-040 req_valid held high throughout a transaction -> exactly one accept per IDLE visit; second transaction starts 1 cycle after done.
REQ-041 Reset asserted during WAIT_DONE of op 2 -> next cycle IDLE, req_ready=1, no done pulse, outputs at reset values.
REQ-042 IDLE_GAP_CYCLES=3 -> exactly 3 cycles between busy falling and the next i2c_start.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: the byte-engine command encodings, the controller FSM state
// encoding and the op-index to command decode. Both i2c_reg_access and
// anything that drives or monitors the byte engine import this package.
//
// Write sequence (ops 0..4): START, TX {dev,0}, TX reg, TX wdata, STOP
// Read sequence  (ops 0..6): START, TX {dev,0}, TX reg, START, TX {dev,1}, RX, STOP
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_TX    = 2'd2,
        CMD_RX    = 2'd3
    } i2c_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4,
        ST_FINISH    = 3'd5
    } state_e;

    localparam logic [2:0] WR_STOP_OP = 3'd4;
    localparam logic [2:0] RD_STOP_OP = 3'd6;

    function automatic logic [2:0] stop_op(input logic rw);
        return rw ? RD_STOP_OP : WR_STOP_OP;
    endfunction

    function automatic i2c_cmd_e op_cmd(input logic rw, input logic [2:0] op);
        i2c_cmd_e c;
        c = CMD_TX;
        if (op == 3'd0)
            c = CMD_START;
        else if (op == stop_op(rw))
            c = CMD_STOP;
        else if (rw && op == 3'd3)
            c = CMD_START;
        else if (rw && op == 3'd5)
            c = CMD_RX;
        return c;
    endfunction

endpackage

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: sequences one register write or register read through an
// external I2C byte engine (START / STOP / TX / RX primitives).
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_rw                  0 = register write, 1 = register read
//   req_dev_addr/_reg_addr  7-bit device address, 8-bit register index
//   req_wdata               write data byte
//   done                    one-cycle pulse at the end of a transaction
//   rdata                   read byte, valid from done until the next done
//   nack                    a TX op saw NACK, valid with done
//   i2c_command/_data_w     command and TX byte to the engine
//   i2c_start               one-cycle engine launch strobe
//   i2c_r_ack               ACK bit the engine drives on RX (always NACK)
//   i2c_busy/_w_ack/_data_r engine status, received ACK (1 = NACK), RX byte
//
// Parameter IDLE_GAP_CYCLES: idle cycles between consecutive engine ops.
// Macro I2C_REG_ACCESS_NACK_ABORT_EN: when defined, a NACK on any TX op
// jumps straight to the STOP op. When undefined the sequence always runs to
// completion and nack is the sticky OR of every TX ACK bit.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | ready for a request; latch fields on accept
// ST_ISSUE     | pulse i2c_start for the current op
// ST_WAIT_ACK  | one cycle while the engine raises busy
// ST_WAIT_DONE | wait for busy low, then evaluate the op result
// ST_GAP       | idle spacing between ops (down-counter to zero)
// ST_FINISH    | done pulse, back to IDLE
module i2c_reg_access
    import i2c_pkg::*;
#(
    parameter int unsigned IDLE_GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       nack,
    output logic [1:0] i2c_command,
    output logic       i2c_start,
    output logic [7:0] i2c_data_w,
    output logic       i2c_r_ack,
    input  logic       i2c_busy,
    input  logic       i2c_w_ack,
    input  logic [7:0] i2c_data_r
);

    localparam int unsigned GAP_W = (IDLE_GAP_CYCLES > 1) ? $clog2(IDLE_GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((IDLE_GAP_CYCLES == 0) ? 0 : IDLE_GAP_CYCLES - 1);

    state_e           state, state_next;
    logic [2:0]       op_idx, op_next;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       wdata_q;
    logic             nack_q;
    logic [7:0]       rx_q;
    logic [7:0]       rdata_q;
    i2c_cmd_e         cmd_q;
    logic [7:0]       data_q;
    logic [7:0]       op_data;
    logic [GAP_W-1:0] gap_cnt;
    logic             op_nack;

    assign op_nack = (cmd_q == CMD_TX) && i2c_w_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            op_idx <= 3'd0;
        end else begin
            state  <= state_next;
            op_idx <= op_next;
        end
    end

    always_comb begin
        state_next = state;
        op_next    = op_idx;
        req_ready  = 1'b0;
        i2c_start  = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_ISSUE;
                    op_next    = 3'd0;
                end
            end
            ST_ISSUE: begin
                i2c_start  = 1'b1;
                state_next = ST_WAIT_ACK;
            end
            // Engine busy is not yet visible in the cycle after the launch.
            ST_WAIT_ACK: state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (!i2c_busy) begin
                    if (cmd_q == CMD_STOP) begin
                        state_next = ST_FINISH;
                    end else begin
                        op_next = op_idx + 3'd1;
`ifdef I2C_REG_ACCESS_NACK_ABORT_EN
                        if (op_nack)
                            op_next = stop_op(rw_q);
`endif
                        state_next = (IDLE_GAP_CYCLES == 0) ? ST_ISSUE : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0)
                    state_next = ST_ISSUE;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // TX byte for the op about to be issued. The latched request fields are
    // used directly: on accept op_next is 0 (START, no data), so the stale
    // fields of the previous request never reach the engine.
    always_comb begin
        op_data = 8'h00;
        case (op_next)
            3'd1:    op_data = {dev_q, 1'b0};
            3'd2:    op_data = reg_q;
            3'd3:    op_data = rw_q ? 8'h00 : wdata_q;
            3'd4:    op_data = rw_q ? {dev_q, 1'b1} : 8'h00;
            default: op_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q    <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            nack_q  <= 1'b0;
            rx_q    <= 8'h00;
            rdata_q <= 8'h00;
            cmd_q   <= CMD_START;
            data_q  <= 8'h00;
            gap_cnt <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                rw_q    <= req_rw;
                dev_q   <= req_dev_addr;
                reg_q   <= req_reg_addr;
                wdata_q <= req_wdata;
                nack_q  <= 1'b0;
                rx_q    <= 8'h00;
            end
            // Command and data change only when entering ISSUE, so they stay
            // stable for the whole ISSUE..WAIT_DONE window.
            if (state_next == ST_ISSUE) begin
                cmd_q  <= op_cmd(rw_q, op_next);
                data_q <= op_data;
            end
            if (state == ST_WAIT_DONE && !i2c_busy) begin
                if (op_nack)
                    nack_q <= 1'b1;
                if (cmd_q == CMD_RX)
                    rx_q <= i2c_data_r;
            end
            if (state_next == ST_GAP && state != ST_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);
            // rdata only moves at the end of a read so it is held across
            // writes and stays stable from one done to the next.
            if (state_next == ST_FINISH && rw_q)
                rdata_q <= rx_q;
        end
    end

    assign rdata       = rdata_q;
    assign nack        = nack_q;
    assign i2c_command = cmd_q;
    assign i2c_data_w  = data_q;
    assign i2c_r_ack   = 1'b1;

endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench for i2c_reg_access with a behavioural byte-engine model.
// A second instance with IDLE_GAP_CYCLES=3 checks inter-op spacing.
module tb_i2c_reg_access;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_valid_g;
    logic       req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;

    logic       req_ready, done, nack, i2c_start, i2c_r_ack;
    logic [7:0] rdata, i2c_data_w;
    logic [1:0] i2c_command;
    logic       busy, w_ack;
    logic [7:0] data_r;

    logic       req_ready_g, done_g, nack_g, i2c_start_g, i2c_r_ack_g;
    logic [7:0] rdata_g, i2c_data_w_g;
    logic [1:0] i2c_command_g;
    logic       busy_g;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cnt_g = 0;
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic [7:0]  nack_byte = 8'hFF;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  rdata_at_done;

    logic [2:0]  bcnt, bcnt_g;
    logic [1:0]  last_cmd;
    logic [7:0]  last_data;
    int          fall_m = 0, gap_m = 0, fall_g = 0, gap_g = 0;

    always #5 clk = ~clk;

    i2c_reg_access dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .done(done), .rdata(rdata), .nack(nack),
        .i2c_command(i2c_command), .i2c_start(i2c_start), .i2c_data_w(i2c_data_w),
        .i2c_r_ack(i2c_r_ack), .i2c_busy(busy), .i2c_w_ack(w_ack), .i2c_data_r(data_r)
    );

    i2c_reg_access #(.IDLE_GAP_CYCLES(3)) dut_g (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_g), .req_ready(req_ready_g), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .done(done_g), .rdata(rdata_g), .nack(nack_g),
        .i2c_command(i2c_command_g), .i2c_start(i2c_start_g), .i2c_data_w(i2c_data_w_g),
        .i2c_r_ack(i2c_r_ack_g), .i2c_busy(busy_g), .i2c_w_ack(1'b0), .i2c_data_r(8'h00)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy rises at the launch edge and stays high 4 cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            bcnt   <= 3'd0;
            w_ack  <= 1'b0;
            data_r <= 8'h00;
        end else if (i2c_start) begin
            log_q.push_back({i2c_r_ack, i2c_command, i2c_data_w});
            busy      <= 1'b1;
            bcnt      <= 3'd4;
            last_cmd  <= i2c_command;
            last_data <= i2c_data_w;
            gap_m     <= cyc - fall_m;
        end else if (busy) begin
            if (bcnt == 3'd1) begin
                busy   <= 1'b0;
                fall_m <= cyc;
                w_ack  <= (last_cmd == 2'd2) && (last_data == nack_byte);
                data_r <= rx_byte;
            end else begin
                bcnt <= bcnt - 3'd1;
            end
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            busy_g <= 1'b0;
            bcnt_g <= 3'd0;
        end else if (i2c_start_g) begin
            busy_g <= 1'b1;
            bcnt_g <= 3'd4;
            gap_g  <= cyc - fall_g;
        end else if (busy_g) begin
            if (bcnt_g == 3'd1) begin
                busy_g <= 1'b0;
                fall_g <= cyc;
            end else begin
                bcnt_g <= bcnt_g - 3'd1;
            end
        end
        if (done_g) done_cnt_g <= done_cnt_g + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [1:0] c, input logic [7:0] d);
        return {1'b1, c, d};
    endfunction

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                rdata_at_done = rdata;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_log(input string tag, input int base);
        logic [10:0] got;
        chk({tag, "_op_count"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < log_q.size()) ? log_q[base + i] : 11'h7FF;
            chk($sformatf("%s_op%0d", tag, i), {21'd0, got}, {21'd0, exp_q[i]});
        end
    endtask

    task automatic run_txn(input string tag, input logic rw, input logic [6:0] dev,
                           input logic [7:0] ra, input logic [7:0] wd);
        req_rw       = rw;
        req_dev_addr = dev;
        req_reg_addr = ra;
        req_wdata    = wd;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
        wait_done(tag);
        tick();
    endtask

    initial begin
        int base;
        int d0;
        logic seen_g;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_valid_g  = 1'b0;
        req_rw       = 1'b0;
        req_dev_addr = 7'h00;
        req_reg_addr = 8'h00;
        req_wdata    = 8'h00;
        repeat (3) tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_nack", {31'd0, nack}, 32'd0);
        chk("rst_rdata", {24'd0, rdata}, 32'h00);
        chk("rst_start", {31'd0, i2c_start}, 32'd0);
        chk("rst_cmd", {30'd0, i2c_command}, 32'd0);
        chk("rst_data_w", {24'd0, i2c_data_w}, 32'h00);
        chk("rst_r_ack", {31'd0, i2c_r_ack}, 32'd1);
        reset = 1'b0;
        tick();

        // Plain write, all ACK.
        base = log_q.size();
        d0   = done_cnt;
        run_txn("wr", 1'b0, 7'h3C, 8'h10, 8'hA5);
        exp_q = {mk(2'd0, 8'h00), mk(2'd2, 8'h78), mk(2'd2, 8'h10), mk(2'd2, 8'hA5), mk(2'd1, 8'h00)};
        check_log("wr", base);
        chk("wr_nack", {31'd0, nack}, 32'd0);
        chk("wr_done_once", done_cnt - d0, 32'd1);
        chk("wr_gap0", gap_m, 32'd2);

        // Read, slave returns 0x5A.
        base    = log_q.size();
        rx_byte = 8'h5A;
        run_txn("rd", 1'b1, 7'h50, 8'h02, 8'h00);
        exp_q = {mk(2'd0, 8'h00), mk(2'd2, 8'hA0), mk(2'd2, 8'h02), mk(2'd0, 8'h00),
                 mk(2'd2, 8'hA1), mk(2'd3, 8'h00), mk(2'd1, 8'h00)};
        check_log("rd", base);
        chk("rd_rdata_at_done", {24'd0, rdata_at_done}, 32'h5A);
        chk("rd_nack", {31'd0, nack}, 32'd0);

        // Address NACK on a write to 0x22.
        base      = log_q.size();
        nack_byte = 8'h44;
        run_txn("nk", 1'b0, 7'h22, 8'h33, 8'h77);
`ifdef I2C_REG_ACCESS_NACK_ABORT_EN
        exp_q = {mk(2'd0, 8'h00), mk(2'd2, 8'h44), mk(2'd1, 8'h00)};
`else
        exp_q = {mk(2'd0, 8'h00), mk(2'd2, 8'h44), mk(2'd2, 8'h33), mk(2'd2, 8'h77), mk(2'd1, 8'h00)};
`endif
        check_log("nk", base);
        chk("nk_nack", {31'd0, nack}, 32'd1);
        chk("nk_rdata_held", {24'd0, rdata}, 32'h5A);
        nack_byte = 8'hFF;

        // req_valid held through two transactions.
        base         = log_q.size();
        d0           = done_cnt;
        req_rw       = 1'b0;
        req_dev_addr = 7'h11;
        req_reg_addr = 8'h01;
        req_wdata    = 8'h02;
        req_valid    = 1'b1;
        wait_done("b2b1");
        chk("b2b1_nack_cleared", {31'd0, nack}, 32'd0);
        tick();
        chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("b2b_issue", {31'd0, i2c_start}, 32'd1);
        wait_done("b2b2");
        req_valid = 1'b0;
        repeat (10) tick();
        chk("b2b_ops", log_q.size() - base, 32'd10);
        chk("b2b_dones", done_cnt - d0, 32'd2);
        chk("b2b_idle_after", {31'd0, req_ready}, 32'd1);

        // Reset during WAIT_DONE of op 2.
        base         = log_q.size();
        d0           = done_cnt;
        req_rw       = 1'b0;
        req_dev_addr = 7'h3C;
        req_reg_addr = 8'h10;
        req_wdata    = 8'hA5;
        req_valid    = 1'b1;
        tick();
        req_valid    = 1'b0;
        for (int i = 0; i < 100 && (log_q.size() - base) < 3; i++) tick();
        chk("mr_reached_op2", log_q.size() - base, 32'd3);
        tick();
        chk("mr_in_wait_done_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mr_ready", {31'd0, req_ready}, 32'd1);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_start", {31'd0, i2c_start}, 32'd0);
        chk("mr_cmd", {30'd0, i2c_command}, 32'd0);
        chk("mr_data_w", {24'd0, i2c_data_w}, 32'h00);
        chk("mr_rdata", {24'd0, rdata}, 32'h00);
        chk("mr_nack", {31'd0, nack}, 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        chk("mr_no_done", done_cnt - d0, 32'd0);
        chk("mr_no_more_ops", log_q.size() - base, 32'd3);

        // Gap instance: 3 idle cycles between busy falling and next start.
        req_rw       = 1'b0;
        req_dev_addr = 7'h3C;
        req_reg_addr = 8'h10;
        req_wdata    = 8'hA5;
        req_valid_g  = 1'b1;
        tick();
        req_valid_g  = 1'b0;
        seen_g = 1'b0;
        for (int i = 0; i < 300 && !seen_g; i++) begin
            tick();
            if (done_g === 1'b1) seen_g = 1'b1;
        end
        chk("gap_done_seen", {31'd0, seen_g}, 32'd1);
        chk("gap_spacing", gap_g, 32'd5);
        tick();
        chk("gap_done_once", done_cnt_g, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
